// File: rtl/video_timing_irq_if.sv
// Bus bundle between the video timing engine (slave) and its CPU/pixel-side user (master).
// Carries the interrupt controls in and the divider, counter, sync and interrupt state out.
interface video_timing_irq_if #(
  parameter int CW = 10,
  parameter int SW = 10
);
  logic [1:0]    irq_enable;
  logic [1:0]    irq_ack;
  logic [SW-1:0] irq_line;
  logic          pixel_tick;
  logic [2:0]    sub_count;
  logic [CW-1:0] cycle;
  logic [SW-1:0] scanline;
  logic          vga_hs;
  logic          vga_vs;
  logic          vga_blank;
  logic          frame_start;
  logic [1:0]    irq_status;
  logic          irq;

  modport master (
    output irq_enable, irq_ack, irq_line,
    input  pixel_tick, sub_count, cycle, scanline, vga_hs, vga_vs, vga_blank,
           frame_start, irq_status, irq
  );

  modport slave (
    input  irq_enable, irq_ack, irq_line,
    output pixel_tick, sub_count, cycle, scanline, vga_hs, vga_vs, vga_blank,
           frame_start, irq_status, irq
  );
endinterface

// File: rtl/video_timing_irq.sv
// Video timing engine: pixel-enable divider, cycle/scanline counters, registered sync/blank
// decodes, and sticky vblank/raster interrupts. Raster compare is built only with VIDEO_RASTER_IRQ_EN.
module video_timing_irq #(
  parameter int DIVISION  = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CW        = 10,
  parameter int SW        = 10
) (
  input  logic              CLK100MHz,
  input  logic              rst,
  video_timing_irq_if.slave bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [2:0]    SUB_LAST = 3'(DIVISION - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [SW-1:0] V_LAST   = SW'(V_TOTAL - 1);
  localparam logic [SW-1:0] V_VBLANK = SW'(V_VISIBLE);

  // One extra bit so a sync window ending exactly at 2^CW (or 2^SW) does not truncate to zero.
  localparam logic [CW:0] H_VIS_X  = (CW+1)'(H_VISIBLE);
  localparam logic [CW:0] HS_START = (CW+1)'(H_VISIBLE + H_FRONT);
  localparam logic [CW:0] HS_END   = (CW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [SW:0] V_VIS_X  = (SW+1)'(V_VISIBLE);
  localparam logic [SW:0] VS_START = (SW+1)'(V_VISIBLE + V_FRONT);
  localparam logic [SW:0] VS_END   = (SW+1)'(V_VISIBLE + V_FRONT + V_SYNC);

`ifdef VIDEO_RASTER_IRQ_EN
  localparam logic [1:0] IRQ_BITS = 2'b11;
`else
  localparam logic [1:0] IRQ_BITS = 2'b01;
`endif

  logic [2:0]    sub_q, sub_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_q, blank_d;
  logic          fs_q, fs_d;
  logic [1:0]    st_q, st_d;
  logic [1:0]    ev;
  logic          advance;
  logic          land_col0;

  always_comb begin
    advance = (sub_q == SUB_LAST);
    sub_d   = advance ? 3'd0 : sub_q + 3'd1;
    cyc_d   = cyc_q;
    scan_d  = scan_q;
    if (advance) begin
      if (cyc_q == H_LAST) begin
        cyc_d  = '0;
        scan_d = (scan_q == V_LAST) ? '0 : scan_q + SW'(1);
      end else begin
        cyc_d = cyc_q + CW'(1);
      end
    end

    // Decodes use next-state counters so they land on the same edge as the counters.
    hs_d = (({1'b0, cyc_d} >= HS_START) && ({1'b0, cyc_d} < HS_END)) ? HS_POL : ~HS_POL;
    vs_d = (({1'b0, scan_d} >= VS_START) && ({1'b0, scan_d} < VS_END)) ? VS_POL : ~VS_POL;
    blank_d = ({1'b0, cyc_d} >= H_VIS_X) || ({1'b0, scan_d} >= V_VIS_X);

    land_col0 = advance && (cyc_d == '0);
    fs_d      = land_col0 && (scan_d == '0);
    ev[0]     = land_col0 && (scan_d == V_VBLANK);
`ifdef VIDEO_RASTER_IRQ_EN
    ev[1]     = land_col0 && (scan_d == bus.irq_line);
`else
    ev[1]     = 1'b0;
`endif
  end

`ifndef VIDEO_RASTER_IRQ_EN
  logic unused_raster;
  assign unused_raster = ^bus.irq_line;
`endif

  // An event on the same edge as its ack keeps the bit set.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_status
      assign st_d[gi] = IRQ_BITS[gi] & (ev[gi] | (st_q[gi] & ~bus.irq_ack[gi]));
    end
  endgenerate

  always_ff @(posedge CLK100MHz or posedge rst) begin
    if (rst) begin
      sub_q   <= '0;
      cyc_q   <= '0;
      scan_q  <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      st_q    <= '0;
    end else begin
      sub_q   <= sub_d;
      cyc_q   <= cyc_d;
      scan_q  <= scan_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      st_q    <= st_d;
    end
  end

  assign bus.pixel_tick  = advance;
  assign bus.sub_count   = sub_q;
  assign bus.cycle       = cyc_q;
  assign bus.scanline    = scan_q;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank   = blank_q;
  assign bus.frame_start = fs_q;
  assign bus.irq_status  = st_q;
  assign bus.irq         = |(st_q & bus.irq_enable);

endmodule

// File: tb/tb_video_timing_irq.sv
// Directed bench for video_timing_irq in a 12x7 mode with DIVISION=2, HS_POL=0, VS_POL=1.
// A per-clock reference model pushes expected state to a queue; it is popped after each edge.
module tb_video_timing_irq;

`ifdef VIDEO_RASTER_IRQ_EN
  localparam bit RASTER = 1'b1;
`else
  localparam bit RASTER = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] sub;
    logic [3:0] cyc;
    logic [3:0] scan;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  video_timing_irq_if #(.CW(4), .SW(4)) bus ();

  video_timing_irq #(
    .DIVISION(2),
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b1),
    .CW(4), .SW(4)
  ) dut (
    .CLK100MHz(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   tick_cnt = 0;
  int   fs_cnt = 0;
  int   st1_seen = 0;
  exp_t m;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t reset_model();
    exp_t r;
    r.sub = 3'd0; r.cyc = 4'd0; r.scan = 4'd0;
    r.hs = 1'b1; r.vs = 1'b0; r.blank = 1'b0; r.fs = 1'b0; r.st = 2'b00;
    return r;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_sub"},   bus.sub_count,   16'd0);
    chk({tag, "_cyc"},   bus.cycle,       16'd0);
    chk({tag, "_scan"},  bus.scanline,    16'd0);
    chk({tag, "_hs"},    bus.vga_hs,      16'd1);
    chk({tag, "_vs"},    bus.vga_vs,      16'd0);
    chk({tag, "_blank"}, bus.vga_blank,   16'd0);
    chk({tag, "_fs"},    bus.frame_start, 16'd0);
    chk({tag, "_st"},    bus.irq_status,  16'd0);
    chk({tag, "_irq"},   bus.irq,         16'd0);
    chk({tag, "_tick"},  bus.pixel_tick,  16'd0);
  endtask

  // One clock: check combinational outputs, predict the next state, then compare after the edge.
  task automatic step();
    exp_t e;
    exp_t got;
    bit   adv;
    int   nc;
    int   ns;
    bit   ev0;
    bit   ev1;
    #1;
    chk("pixel_tick", bus.pixel_tick, 16'(m.sub == 3'd1));
    chk("irq_comb", bus.irq, 16'(|(m.st & bus.irq_enable)));
    if (bus.pixel_tick === 1'b1) tick_cnt++;
    adv = (m.sub == 3'd1);
    nc  = int'(m.cyc);
    ns  = int'(m.scan);
    e   = m;
    e.sub = adv ? 3'd0 : m.sub + 3'd1;
    e.fs  = 1'b0;
    if (adv) begin
      if (nc == 11) begin
        nc = 0;
        ns = (ns == 6) ? 0 : ns + 1;
      end else begin
        nc = nc + 1;
      end
      e.cyc   = 4'(nc);
      e.scan  = 4'(ns);
      e.hs    = !(nc == 9 || nc == 10);
      e.vs    = (ns == 5);
      e.blank = (nc >= 8) || (ns >= 4);
      e.fs    = (nc == 0) && (ns == 0);
    end
    ev0 = adv && (nc == 0) && (ns == 4);
    ev1 = RASTER && adv && (nc == 0) && (ns == int'(bus.irq_line));
    e.st[0] = ev0 | (m.st[0] & ~bus.irq_ack[0]);
    e.st[1] = ev1 | (m.st[1] & ~(RASTER & bus.irq_ack[1]));
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("sub_count",   bus.sub_count,   16'(got.sub));
    chk("cycle",       bus.cycle,       16'(got.cyc));
    chk("scanline",    bus.scanline,    16'(got.scan));
    chk("vga_hs",      bus.vga_hs,      16'(got.hs));
    chk("vga_vs",      bus.vga_vs,      16'(got.vs));
    chk("vga_blank",   bus.vga_blank,   16'(got.blank));
    chk("frame_start", bus.frame_start, 16'(got.fs));
    chk("irq_status",  bus.irq_status,  16'(got.st));
    if (bus.frame_start === 1'b1) fs_cnt++;
    if (bus.irq_status[1] === 1'b1) st1_seen++;
    m = got;
  endtask

  task automatic run_until(input int c, input int s, input string tag);
    int n = 0;
    while (!(m.sub == 3'd0 && int'(m.cyc) == c && int'(m.scan) == s) && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_reached"}, 16'(n < 200), 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.irq_enable = 2'b00;
    bus.irq_ack    = 2'b00;
    bus.irq_line   = 4'd0;
    m = reset_model();

    // Reset state, then release on a falling edge
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // First line: ticks every 2nd clock, cycle 0..11 then 0, scanline 1
    tick_cnt = 0;
    repeat (24) step();
    chk("ticks_in_24", 16'(tick_cnt), 16'd12);
    chk("cycle_after_24", bus.cycle, 16'd0);
    chk("scan_after_24", bus.scanline, 16'd1);

    // One full frame: exactly one frame_start
    fs_cnt = 0;
    repeat (168) step();
    chk("frame_start_count", 16'(fs_cnt), 16'd1);
    bus.irq_ack = 2'b11;
    step();
    bus.irq_ack = 2'b00;

    // Vblank interrupt, then ack
    bus.irq_enable = 2'b01;
    run_until(0, 4, "vblank");
    chk("vblank_status", bus.irq_status[0], 16'd1);
    chk("vblank_irq", bus.irq, 16'd1);
    bus.irq_ack = 2'b01;
    step();
    bus.irq_ack = 2'b00;
    chk("vblank_ack_status", bus.irq_status[0], 16'd0);
    chk("vblank_ack_irq", bus.irq, 16'd0);

    // Raster interrupt at line 2
    bus.irq_ack = 2'b11;
    step();
    bus.irq_ack    = 2'b00;
    bus.irq_line   = 4'd2;
    bus.irq_enable = 2'b10;
    step();
    chk("raster_pre_irq", bus.irq, 16'd0);
    run_until(0, 2, "raster");
    chk("raster_irq", bus.irq, 16'(RASTER));
    bus.irq_ack = 2'b10;
    step();
    bus.irq_ack = 2'b00;
    chk("raster_ack_status", bus.irq_status[1], 16'd0);

    // Out-of-range raster line never fires
    bus.irq_line = 4'd9;
    st1_seen = 0;
    repeat (504) step();
    chk("raster_out_of_range", 16'(st1_seen), 16'd0);

    // Ack held across the vblank edge: event wins
    bus.irq_enable = 2'b01;
    bus.irq_ack    = 2'b01;
    run_until(0, 4, "vblank_ackheld");
    chk("event_beats_ack", bus.irq_status[0], 16'd1);
    bus.irq_ack = 2'b00;

    // Mid-frame async reset at (5,3) with an interrupt pending
    run_until(5, 3, "pos_5_3");
    chk("pending_before_reset", bus.irq, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m = reset_model();
    repeat (30) step();
    chk("resume_cycle", bus.cycle, 16'd3);
    chk("resume_scan", bus.scanline, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
